// File: rtl/soc_peripheral_block.sv
// Bus-mapped GPIO (64 out / 64 in) plus optional 8N1 UART behind a req/gnt/rvalid/err bus.
// The UART is built only when PERIPHERAL_UART_EN is defined. TX/RX FSM states:
//   state   | meaning
//   S_IDLE  | line idle, waiting for a TX write / RX falling edge
//   S_START | start bit (RX: half-bit re-check of the start bit)
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit
module soc_peripheral_block (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic [63:0] gpio_out,
  input  logic [63:0] gpio_in,
  input  logic        uart_clk,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam logic [9:0] OFF_OUT_LO = 10'h000;
  localparam logic [9:0] OFF_OUT_HI = 10'h001;
  localparam logic [9:0] OFF_IN_LO  = 10'h002;
  localparam logic [9:0] OFF_IN_HI  = 10'h003;
  localparam logic [9:0] OFF_TX     = 10'h040;
  localparam logic [9:0] OFF_RX     = 10'h041;
  localparam logic [9:0] OFF_STAT   = 10'h042;

  logic        in_win, wr, rd;
  logic [9:0]  woff;
  logic [31:0] out_lo_q, out_lo_d, out_hi_q, out_hi_d;
  logic [63:0] gin_s1_q, gin_s2_q;
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        unused_ok;

  assign in_win    = data_addr[31:12] == 20'h80000;
  assign woff      = data_addr[11:2];
  assign wr        = data_req & data_we & in_win;
  assign rd        = data_req & ~data_we & in_win;
  assign unused_ok = ^data_addr[1:0];

  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

`ifdef PERIPHERAL_UART_EN
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic        uclk_s1_q, uclk_s2_q, uclk_s3_q, tick;
  logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [3:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
  logic        tx_busy, tx_start, rx_done, rx_rd, stat_clr, valid_kept;

  assign tick     = uclk_s2_q & ~uclk_s3_q;
  assign rx_fall  = rx_s3_q & ~rx_s2_q;
  assign tx_start = wr & (woff == OFF_TX) & data_be[0] & (tx_state_q == S_IDLE);
  assign rx_rd    = rd & (woff == OFF_RX);
  assign stat_clr = wr & (woff == OFF_STAT) & data_wdata[2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      {uclk_s1_q, uclk_s2_q, uclk_s3_q} <= 3'b000;
      {rx_s1_q, rx_s2_q, rx_s3_q}       <= 3'b111;
      tx_state_q <= S_IDLE;  tx_cnt_q <= '0;  tx_bit_q <= '0;  tx_shift_q <= '0;
      rx_state_q <= S_IDLE;  rx_cnt_q <= '0;  rx_bit_q <= '0;  rx_shift_q <= '0;
      rx_byte_q  <= '0;  rx_valid_q <= 1'b0;  rx_overrun_q <= 1'b0;
    end else begin
      {uclk_s1_q, uclk_s2_q, uclk_s3_q} <= {uart_clk, uclk_s1_q, uclk_s2_q};
      {rx_s1_q, rx_s2_q, rx_s3_q}       <= {uart_rx, rx_s1_q, rx_s2_q};
      tx_state_q <= tx_state_d;  tx_cnt_q <= tx_cnt_d;  tx_bit_q <= tx_bit_d;  tx_shift_q <= tx_shift_d;
      rx_state_q <= rx_state_d;  rx_cnt_q <= rx_cnt_d;  rx_bit_q <= rx_bit_d;  rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;  rx_valid_q <= rx_valid_d;  rx_overrun_q <= rx_overrun_d;
    end
  end

  // Per-bit tick counters count down; a bit ends on the tick that finds zero.
  always_comb begin
    tx_state_d = tx_state_q;  tx_cnt_d = tx_cnt_q;  tx_bit_d = tx_bit_q;  tx_shift_d = tx_shift_q;
    case (tx_state_q)
      S_IDLE:
        if (tx_start) begin
          tx_state_d = S_START;  tx_cnt_d = 4'd15;  tx_shift_d = data_wdata[7:0];
        end
      S_START:
        if (tick) begin
          if (tx_cnt_q == 4'd0) begin
            tx_state_d = S_DATA;  tx_cnt_d = 4'd15;  tx_bit_d = 3'd7;
          end else tx_cnt_d = tx_cnt_q - 4'd1;
        end
      S_DATA:
        if (tick) begin
          if (tx_cnt_q == 4'd0) begin
            tx_cnt_d   = 4'd15;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            if (tx_bit_q == 3'd0) tx_state_d = S_STOP;
            else tx_bit_d = tx_bit_q - 3'd1;
          end else tx_cnt_d = tx_cnt_q - 4'd1;
        end
      default:
        if (tick) begin
          if (tx_cnt_q == 4'd0) tx_state_d = S_IDLE;
          else tx_cnt_d = tx_cnt_q - 4'd1;
        end
    endcase
  end

  always_comb begin
    tx_busy = tx_state_q != S_IDLE;
    case (tx_state_q)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = tx_shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;  rx_cnt_d = rx_cnt_q;  rx_bit_d = rx_bit_q;  rx_shift_d = rx_shift_q;
    case (rx_state_q)
      S_IDLE:
        if (rx_fall) begin
          rx_state_d = S_START;  rx_cnt_d = 4'd7;
        end
      S_START:
        if (tick) begin
          if (rx_cnt_q == 4'd0) begin
            if (!rx_s2_q) begin
              rx_state_d = S_DATA;  rx_cnt_d = 4'd15;  rx_bit_d = 3'd7;
            end else rx_state_d = S_IDLE;
          end else rx_cnt_d = rx_cnt_q - 4'd1;
        end
      S_DATA:
        if (tick) begin
          if (rx_cnt_q == 4'd0) begin
            rx_cnt_d   = 4'd15;
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd0) rx_state_d = S_STOP;
            else rx_bit_d = rx_bit_q - 3'd1;
          end else rx_cnt_d = rx_cnt_q - 4'd1;
        end
      default:
        if (tick) begin
          if (rx_cnt_q == 4'd0) rx_state_d = S_IDLE;
          else rx_cnt_d = rx_cnt_q - 4'd1;
        end
    endcase
  end

  always_comb begin
    rx_done = (rx_state_q == S_STOP) & tick & (rx_cnt_q == 4'd0) & rx_s2_q;
  end

  // A read in the completing cycle frees the buffer, so the new byte is stored.
  always_comb begin
    valid_kept   = rx_valid_q & ~rx_rd;
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = valid_kept;
    rx_overrun_d = rx_overrun_q & ~stat_clr;
    if (rx_done) begin
      if (!valid_kept) begin
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else rx_overrun_d = 1'b1;
    end
  end
`else
  logic unused_uart;
  assign unused_uart = uart_clk ^ uart_rx;
  assign uart_tx     = 1'b1;
`endif

  always_comb begin
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;
    if (wr && woff == OFF_OUT_LO) out_lo_d = be_merge(out_lo_q, data_wdata, data_be);
    if (wr && woff == OFF_OUT_HI) out_hi_d = be_merge(out_hi_q, data_wdata, data_be);
  end

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (data_req) begin
      if (!in_win) err_d = 1'b1;
      else begin
        case (woff)
          OFF_OUT_LO: rdata_d = data_we ? '0 : out_lo_q;
          OFF_OUT_HI: rdata_d = data_we ? '0 : out_hi_q;
          OFF_IN_LO:  rdata_d = data_we ? '0 : gin_s2_q[31:0];
          OFF_IN_HI:  rdata_d = data_we ? '0 : gin_s2_q[63:32];
`ifdef PERIPHERAL_UART_EN
          OFF_TX:     rdata_d = '0;
          OFF_RX:     rdata_d = data_we ? '0 : {23'b0, rx_valid_q, rx_byte_q};
          OFF_STAT:   rdata_d = data_we ? '0 : {29'b0, rx_overrun_q, rx_valid_q, tx_busy};
`endif
          default:    err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_lo_q <= '0;  out_hi_q <= '0;
      gin_s1_q <= '0;  gin_s2_q <= '0;
      rvalid_q <= 1'b0;  rdata_q <= '0;  err_q <= 1'b0;
    end else begin
      out_lo_q <= out_lo_d;  out_hi_q <= out_hi_d;
      gin_s1_q <= gpio_in;   gin_s2_q <= gin_s1_q;
      rvalid_q <= data_req;  rdata_q <= rdata_d;  err_q <= err_d;
    end
  end

  assign data_gnt    = data_req;
  assign data_rvalid = rvalid_q;
  assign data_rdata  = rdata_q;
  assign data_err    = err_q;
  assign gpio_out    = {out_hi_q, out_lo_q};

endmodule

// File: tb/tb_soc_peripheral_block.sv
// Directed bench for soc_peripheral_block; UART checks follow PERIPHERAL_UART_EN.
module tb_soc_peripheral_block;
  logic        clk = 1'b0, rst = 1'b0;
  logic        data_req = 1'b0, data_we = 1'b0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic [63:0] gpio_out;
  logic [63:0] gpio_in = '0;
  logic        uart_clk = 1'b0, uart_rx = 1'b1, uart_tx;

  int n_assert = 0, n_fail = 0, cyc = 0, t0 = 0;
  logic [31:0] rdv;
  logic        erv, rvv;

  soc_peripheral_block dut (
    .clk(clk), .rst(rst), .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_err(data_err),
    .gpio_out(gpio_out), .gpio_in(gpio_in), .uart_clk(uart_clk), .uart_rx(uart_rx),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #20 uart_clk = ~uart_clk;   // one tick every 4 clk cycles
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output logic rv);
    @(negedge clk);
    data_req = 1'b1;  data_we = we;  data_be = be;  data_addr = addr;  data_wdata = wd;
    @(posedge clk);
    #1;
    rv = data_rvalid;  rd = data_rdata;  er = data_err;
    data_req = 1'b0;  data_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp_d,
                        input logic exp_e);
    logic [31:0] d;
    logic e, v;
    bus(1'b0, 4'h0, addr, 32'h0, d, e, v);
    chk(tag, {31'b0, v, 31'b0, e, d}, {31'b0, 1'b1, 31'b0, exp_e, exp_d});
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic exp_e);
    logic [31:0] d;
    logic e, v;
    bus(1'b1, be, addr, wd, d, e, v);
    chk(tag, {31'b0, v, 31'b0, e, d}, {31'b0, 1'b1, 31'b0, exp_e, 32'h0});
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (64) @(posedge clk);
    end
    uart_rx = 1'b1;
    repeat (16) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gpio_out", gpio_out, 64'h0);
    chk("reset_uart_tx", {63'b0, uart_tx}, 64'h1);
    chk("reset_rsp", {30'b0, data_rvalid, data_err, data_rdata}, 64'h0);
    rst = 1'b1;

    wr_chk("wr_out_lo", 32'h8000_0000, 4'b0101, 32'hDEAD_BEEF, 1'b0);
    chk("gpio_out_lo", gpio_out, 64'h0000_0000_00AD_00EF);
    rd_chk("rd_out_lo", 32'h8000_0000, 32'h00AD_00EF, 1'b0);
    wr_chk("wr_out_hi", 32'h8000_0004, 4'b1111, 32'h1234_5678, 1'b0);
    wr_chk("wr_out_hi_b3", 32'h8000_0007, 4'b1000, 32'hFFFF_FFFF, 1'b0);
    chk("gpio_out_64", gpio_out, 64'hFF34_5678_00AD_00EF);
    rd_chk("rd_out_hi", 32'h8000_0004, 32'hFF34_5678, 1'b0);
    @(posedge clk);
    #1;
    chk("idle_rsp", {30'b0, data_rvalid, data_err, data_rdata}, 64'h0);

    wr_chk("wr_outside", 32'h8000_1000, 4'hF, 32'h0, 1'b1);
    wr_chk("wr_zero_addr", 32'h0000_0000, 4'hF, 32'h0, 1'b1);
    chk("gpio_unchanged", gpio_out, 64'hFF34_5678_00AD_00EF);
    rd_chk("rd_zero_addr", 32'h0000_0000, 32'h0, 1'b1);
    rd_chk("rd_unlisted", 32'h8000_0010, 32'h0, 1'b1);

    // back-to-back: error read then good read, then idle
    @(negedge clk);
    data_req = 1'b1;  data_we = 1'b0;  data_addr = 32'h8000_0010;
    #1 chk("gnt_comb", {63'b0, data_gnt}, 64'h1);
    @(posedge clk);
    #1;
    chk("b2b_first", {30'b0, data_rvalid, data_err, data_rdata}, {30'b0, 2'b11, 32'h0});
    data_addr = 32'h8000_0000;
    @(posedge clk);
    #1;
    chk("b2b_second", {30'b0, data_rvalid, data_err, data_rdata}, {30'b0, 2'b10, 32'h00AD_00EF});
    data_req = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_idle", {30'b0, data_rvalid, data_err, data_rdata}, 64'h0);

    @(negedge clk);
    gpio_in = 64'h0123_4567_89AB_CDEF;
    repeat (2) @(posedge clk);
    rd_chk("rd_in_lo", 32'h8000_0008, 32'h89AB_CDEF, 1'b0);
    rd_chk("rd_in_hi", 32'h8000_000C, 32'h0123_4567, 1'b0);
    wr_chk("wr_ro", 32'h8000_0008, 4'hF, 32'h0, 1'b0);
    rd_chk("rd_in_lo_again", 32'h8000_0008, 32'h89AB_CDEF, 1'b0);

`ifdef PERIPHERAL_UART_EN
    wr_chk("wr_tx", 32'h8000_0100, 4'b0001, 32'h0000_0055, 1'b0);
    t0 = cyc;
    chk("tx_start_low", {63'b0, uart_tx}, 64'h0);
    rd_chk("stat_busy", 32'h8000_0108, 32'h1, 1'b0);
    wr_chk("wr_tx_dropped", 32'h8000_0100, 4'b0001, 32'h0000_00FF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      wait_cyc(t0 + 64 * i + 32);
      chk($sformatf("tx_bit%0d", i), {63'b0, uart_tx}, {63'b0, 1'(i % 2)});
    end
    wait_cyc(t0 + 660);
    rd_chk("stat_done", 32'h8000_0108, 32'h0, 1'b0);
    wait_cyc(t0 + 720);
    chk("tx_idle_after", {63'b0, uart_tx}, 64'h1);
    rd_chk("rd_tx_zero", 32'h8000_0100, 32'h0, 1'b0);

    send_rx(8'hA3, 1'b1);
    rd_chk("stat_rx_valid", 32'h8000_0108, 32'h2, 1'b0);
    rd_chk("rd_rx", 32'h8000_0104, 32'h1A3, 1'b0);
    rd_chk("stat_cleared", 32'h8000_0108, 32'h0, 1'b0);

    send_rx(8'h3C, 1'b1);
    send_rx(8'h5A, 1'b1);
    rd_chk("stat_overrun", 32'h8000_0108, 32'h6, 1'b0);
    wr_chk("wr_clr_ovr", 32'h8000_0108, 4'hF, 32'h4, 1'b0);
    rd_chk("stat_ovr_clr", 32'h8000_0108, 32'h2, 1'b0);
    rd_chk("rd_rx_first", 32'h8000_0104, 32'h13C, 1'b0);

    send_rx(8'h77, 1'b0);
    rd_chk("stat_frame_err", 32'h8000_0108, 32'h0, 1'b0);

    wr_chk("wr_tx_abort", 32'h8000_0100, 4'b0001, 32'h0, 1'b0);
    repeat (100) @(posedge clk);
    chk("tx_mid_frame", {63'b0, uart_tx}, 64'h0);
`else
    rd_chk("no_uart_tx", 32'h8000_0100, 32'h0, 1'b1);
    rd_chk("no_uart_rx", 32'h8000_0104, 32'h0, 1'b1);
    rd_chk("no_uart_stat", 32'h8000_0108, 32'h0, 1'b1);
    wr_chk("no_uart_wr_tx", 32'h8000_0100, 4'b0001, 32'h55, 1'b1);
    for (int i = 0; i < 8; i++) begin
      uart_rx = 1'(i % 2);
      repeat (20) @(posedge clk);
      #1 chk($sformatf("no_uart_txline%0d", i), {63'b0, uart_tx}, 64'h1);
    end
    uart_rx = 1'b1;
`endif

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_tx_high", {63'b0, uart_tx}, 64'h1);
    chk("rst_gpio_out", gpio_out, 64'h0);
    rst = 1'b1;
`ifdef PERIPHERAL_UART_EN
    rd_chk("stat_after_rst", 32'h8000_0108, 32'h0, 1'b0);
`endif
    rd_chk("rd_lo_after_rst", 32'h8000_0000, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
